// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared widths and loader state encoding (optional checksum: IMEM_LOADER_CHECKSUM_EN)
package imem_pkg;

    localparam int INST_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DONE, ST_ERR
    } loader_state_e;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and instruction memory write port bundle
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = 1024
);
    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  o_we;
    logic [AW-1:0]         o_waddr;
    logic [INST_WIDTH-1:0] o_wdata;

    // host / byte source side
    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_we, o_waddr, o_wdata
    );

    // loader side
    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/imem_word_assembler.sv
// rtl/imem_word_assembler.sv - packs four accepted bytes little-endian into one instruction word
module imem_word_assembler
    import imem_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic [7:0]            i_byte,
    input  logic                  i_accept,
    output logic [INST_WIDTH-1:0] o_word,
    output logic                  o_word_done
);

    logic [1:0]  r_cnt;
    logic [23:0] r_bytes;

    // The 4th byte is not stored: it is forwarded straight into the completed word.
    assign o_word      = {i_byte, r_bytes};
    assign o_word_done = i_accept && (r_cnt == 2'd3);

    // Byte counter and placement of bytes 0..2 into their lanes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 2'd0;
            r_bytes <= 24'd0;
        end else if (i_clear) begin
            r_cnt   <= 2'd0;
            r_bytes <= 24'd0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_bytes[7:0]   <= i_byte;
                2'd1:    r_bytes[15:8]  <= i_byte;
                2'd2:    r_bytes[23:16] <= i_byte;
                default: r_bytes        <= r_bytes;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader (optional checksum: IMEM_LOADER_CHECKSUM_EN)
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE      = 1024,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    imem_loader_if.slave bus,
    output logic         o_cpu_hold,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    loader_state_e         r_state;
    logic                  r_we;
    logic [AW-1:0]         r_waddr;
    logic [INST_WIDTH-1:0] r_wdata;
    logic [AW-1:0]         r_idx;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  w_ready;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [INST_WIDTH-1:0] w_word;
    logic                  w_word_done;
    logic                  w_start;

    assign w_accept = bus.i_byte_valid && w_ready;
    assign w_len    = {bus.i_byte, r_len[7:0]};
    assign w_start  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));

    assign bus.o_byte_ready = w_ready;
    assign bus.o_we         = r_we;
    assign bus.o_waddr      = r_waddr;
    assign bus.o_wdata      = r_wdata;

    // Byte intake is open in the header/data/checksum states, closed during a write cycle.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: w_ready = !r_we;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM:                       w_ready = !r_we;
`endif
            default:                       w_ready = 1'b0;
        endcase
    end

    imem_word_assembler u_asm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_start),
        .i_byte      (bus.i_byte),
        .i_accept    (w_accept && (r_state == ST_DATA)),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Load sequencer: header decode, word writes, completion and CPU hold control.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_last     <= 1'b0;
            o_cpu_hold <= HOLD_ON_RESET;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_accept && (r_state != ST_CSUM))
                r_csum <= r_csum ^ bus.i_byte;
`endif
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start) begin
                        r_state    <= ST_LEN_LO;
                        r_idx      <= '0;
                        r_len      <= '0;
                        r_last     <= 1'b0;
                        o_cpu_hold <= 1'b1;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= 8'd0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= bus.i_byte;
                        r_state    <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_DONE;
                            o_cpu_hold <= 1'b0;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
`endif
                        end else if (32'(w_len) > 32'(MEM_SIZE)) begin
                            r_state <= ST_ERR;
                            o_busy  <= 1'b0;
                            o_err   <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_done) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_idx;
                        r_wdata <= w_word;
                        r_idx   <= r_idx + 1'b1;
                        r_last  <= (32'(r_idx) == 32'(r_len) - 32'd1);
                    end
                    // Leave only once the final word's write strobe has been issued.
                    if (r_we && r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_state    <= ST_CSUM;
`else
                        r_state    <= ST_DONE;
                        o_cpu_hold <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        o_busy <= 1'b0;
                        if (bus.i_byte == r_csum) begin
                            r_state    <= ST_DONE;
                            o_cpu_hold <= 1'b0;
                            o_done     <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            o_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;
    import imem_pkg::*;

    localparam int MEM_SIZE = 1024;
    localparam int AW       = $clog2(MEM_SIZE);

    logic clk;
    logic rst_n;
    logic start;
    logic cpu_hold, busy, done, err;

    imem_loader_if #(.MEM_SIZE(MEM_SIZE)) bus ();

    imem_loader #(.MEM_SIZE(MEM_SIZE), .HOLD_ON_RESET(1'b1)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .bus        (bus),
        .o_cpu_hold (cpu_hold),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wq_addr[$];
    logic [31:0]   wq_data[$];
    int            n_acc;
    int            we_ready_viol;
    logic [7:0]    tb_xor;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record writes and accepted bytes away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_we) begin
                wq_addr.push_back(bus.o_waddr);
                wq_data.push_back(bus.o_wdata);
                if (bus.o_byte_ready !== 1'b0) we_ready_viol++;
            end
            if (bus.i_byte_valid && bus.o_byte_ready) n_acc++;
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        n_acc         = 0;
        we_ready_viol = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tb_xor = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.o_byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%02h ready stayed=%0b required=1", b, bus.o_byte_ready);
        end
        @(posedge clk);
        #1;
        bus.i_byte_valid = 1'b0;
        tb_xor = tb_xor ^ b;
    endtask

    // Checksum builds need the trailing byte before the load can complete.
    task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.o_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", bus.o_we); end
        checks++; if (bus.o_byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.o_byte_ready); end
        checks++; if (bus.o_waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%0h exp=0", bus.o_waddr); end
        checks++; if (bus.o_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%08h exp=0", bus.o_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%0b exp=1", cpu_hold); end
        checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_status got=%03b exp=000", {busy, done, err}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        checks++; if (bus.o_byte_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%0b exp=0", bus.o_byte_ready); end
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start();
        checks++; if ({cpu_hold, busy, done, err} !== 4'b1100) begin failures++; $display("FAIL basic_started got=%04b exp=1100", {cpu_hold, busy, done, err}); end
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h37); send_byte(8'h01); send_byte(8'h00); send_byte(8'hf0);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        tick(2);
        send_trailer();
        tick(1);
        checks++; if (wq_addr.size() !== 2) begin failures++; $display("FAIL basic_nwrites got=%0d exp=2", wq_addr.size()); end
        if (wq_addr.size() == 2) begin
            checks++; if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'hf0000137) begin failures++; $display("FAIL basic_w0 got=%0d/%08h exp=0/f0000137", wq_addr[0], wq_data[0]); end
            checks++; if (wq_addr[1] !== 10'd1 || wq_data[1] !== 32'h00010113) begin failures++; $display("FAIL basic_w1 got=%0d/%08h exp=1/00010113", wq_addr[1], wq_data[1]); end
        end
        checks++; if ({cpu_hold, busy, done, err} !== 4'b0010) begin failures++; $display("FAIL basic_done got=%04b exp=0010", {cpu_hold, busy, done, err}); end
    endtask

    task automatic test_oversize();
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h04);
        tick(3);
        checks++; if ({cpu_hold, busy, done, err} !== 4'b1001) begin failures++; $display("FAIL oversize_status got=%04b exp=1001", {cpu_hold, busy, done, err}); end
        checks++; if (wq_addr.size() !== 0) begin failures++; $display("FAIL oversize_writes got=%0d exp=0", wq_addr.size()); end
        checks++; if (bus.o_byte_ready !== 1'b0) begin failures++; $display("FAIL oversize_ready got=%0b exp=0", bus.o_byte_ready); end
    endtask

    task automatic test_zero_length();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        clear_log();
        checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL zero_hold_before got=%0b exp=1", cpu_hold); end
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        send_trailer();
        checks++; if ({cpu_hold, busy, done, err} !== 4'b0010) begin failures++; $display("FAIL zero_done got=%04b exp=0010", {cpu_hold, busy, done, err}); end
        tick(2);
        checks++; if (wq_addr.size() !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wq_addr.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [12];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'ha1, 8'hb2, 8'hc3, 8'hd4, 8'hde, 8'had, 8'hbe, 8'hef};
        clear_log();
        pulse_start();
        send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, 3));
            if (i == 6) begin
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            send_byte(bytes[i]);
        end
        tick(2);
        send_trailer();
        tick(1);
        checks++; if (n_acc !== 14 + ((tb_xor === 8'hxx) ? 1 : 0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            + 1
`endif
            ) begin failures++; $display("FAIL bp_accepted got=%0d exp=14", n_acc); end
        checks++; if (wq_addr.size() !== 3) begin failures++; $display("FAIL bp_nwrites got=%0d exp=3", wq_addr.size()); end
        if (wq_addr.size() == 3) begin
            checks++; if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'h44332211) begin failures++; $display("FAIL bp_w0 got=%0d/%08h exp=0/44332211", wq_addr[0], wq_data[0]); end
            checks++; if (wq_addr[1] !== 10'd1 || wq_data[1] !== 32'hd4c3b2a1) begin failures++; $display("FAIL bp_w1 got=%0d/%08h exp=1/d4c3b2a1", wq_addr[1], wq_data[1]); end
            checks++; if (wq_addr[2] !== 10'd2 || wq_data[2] !== 32'hefbeadde) begin failures++; $display("FAIL bp_w2 got=%0d/%08h exp=2/efbeadde", wq_addr[2], wq_data[2]); end
        end
        checks++; if (we_ready_viol !== 0) begin failures++; $display("FAIL bp_ready_during_we got=%0d exp=0", we_ready_viol); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%0b exp=1", done); end
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h37); send_byte(8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({cpu_hold, busy, done, err} !== 4'b1000) begin failures++; $display("FAIL rst_mid_status got=%04b exp=1000", {cpu_hold, busy, done, err}); end
        checks++; if ({bus.o_we, bus.o_byte_ready} !== 2'b00) begin failures++; $display("FAIL rst_mid_we_ready got=%02b exp=00", {bus.o_we, bus.o_byte_ready}); end
        checks++; if (bus.o_waddr !== '0 || bus.o_wdata !== 32'h0) begin failures++; $display("FAIL rst_mid_bus got=%0h/%08h exp=0/0", bus.o_waddr, bus.o_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
        tick(2);
        send_trailer();
        tick(1);
        checks++; if (wq_addr.size() !== 1) begin failures++; $display("FAIL rst_reload_nwrites got=%0d exp=1", wq_addr.size()); end
        if (wq_addr.size() == 1) begin
            checks++; if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'hddccbbaa) begin failures++; $display("FAIL rst_reload_w0 got=%0d/%08h exp=0/ddccbbaa", wq_addr[0], wq_data[0]); end
        end
        checks++; if ({cpu_hold, done} !== 2'b01) begin failures++; $display("FAIL rst_reload_done got=%02b exp=01", {cpu_hold, done}); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        // XOR of 01 00 6f f0 1f ff is 7e.
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h6f); send_byte(8'hf0); send_byte(8'h1f); send_byte(8'hff);
        tick(2);
        send_byte(8'h7e);
        checks++; if ({cpu_hold, done, err} !== 3'b010) begin failures++; $display("FAIL csum_match got=%03b exp=010", {cpu_hold, done, err}); end
        clear_log();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h6f); send_byte(8'hf0); send_byte(8'h1f); send_byte(8'hff);
        tick(2);
        send_byte(8'h00);
        checks++; if ({cpu_hold, done, err} !== 3'b101) begin failures++; $display("FAIL csum_mismatch got=%03b exp=101", {cpu_hold, done, err}); end
        checks++; if (wq_data.size() !== 1) begin failures++; $display("FAIL csum_written got=%0d exp=1", wq_data.size()); end
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        tb_xor           = 8'h00;
        clear_log();
        test_reset();
        test_basic_load();
        test_oversize();
        test_zero_length();
        test_backpressure();
        test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
